// File: rtl/gray_pkg.sv
// Shared definitions for the pipelined Gray-to-binary decoder: default sizes,
// snapshot handshake states and the multi-bit-step test.
package gray_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int STAGES_DEF = 4;
  // Difference words are widened to this size before the step test.
  localparam int POP_W      = 64;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } snap_state_e;

  // True when more than one bit is set: clearing the lowest set bit leaves something.
  function automatic logic multi_bit_step(input logic [POP_W-1:0] diff);
    return (diff & (diff - POP_W'(1))) != '0;
  endfunction

endpackage

// File: rtl/gray_dec_stage.sv
// One decoder pipeline slice: converts bits [HI:LO] of the working word from
// Gray to binary, using the binary bit just above the slice as the carry.
module gray_dec_stage
  import gray_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STAGES = STAGES_DEF,
  parameter int IDX    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] w_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] w_o,
  output logic             valid_o
);

  localparam int S  = WIDTH / STAGES;
  localparam int HI = WIDTH - 1 - (IDX - 1) * S;
  localparam int LO = WIDTH - IDX * S;

  // Working word: bits above HI are already binary, bits at/below HI still Gray.
  logic [WIDTH-1:0] w_q, w_d;
  logic             valid_q;
  logic             carry_in;
  logic             carry;

  if (IDX == 1) begin : g_msb
    assign carry_in = 1'b0;
  end else begin : g_inner
    assign carry_in = w_i[HI+1];
  end

  always_comb begin
    w_d   = w_i;
    carry = carry_in;
    for (int i = HI; i >= LO; i--) begin
      carry  = carry ^ w_i[i];
      w_d[i] = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      w_q     <= w_d;
      valid_q <= valid_i;
    end
  end

  assign w_o     = w_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/gray_decode32.sv
// Pipelined Gray-to-binary decoder with single-step checking on the input and
// a four-phase snapshot handshake on the output.
module gray_decode32
  import gray_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] g_in,
  input  logic             g_valid,
  output logic [WIDTH-1:0] b_out,
  output logic             b_valid,
  output logic             step_err,
  output logic [7:0]       err_cnt,
  input  logic             snap_req,
  output logic             snap_ack,
  output logic [WIDTH-1:0] snap_val
);

  // ---------------- decode pipeline ----------------
  logic [WIDTH-1:0]              in_g_q;
  logic                          in_v_q;
  logic [STAGES:0][WIDTH-1:0]    w_pipe;
  logic [STAGES:0]               v_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_g_q <= '0;
      in_v_q <= 1'b0;
    end else begin
      in_g_q <= g_in;
      in_v_q <= g_valid;
    end
  end

  assign w_pipe[0] = in_g_q;
  assign v_pipe[0] = in_v_q;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    gray_dec_stage #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .IDX    (gi + 1)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .w_i     (w_pipe[gi]),
      .valid_i (v_pipe[gi]),
      .w_o     (w_pipe[gi+1]),
      .valid_o (v_pipe[gi+1])
    );
  end

  assign b_out   = w_pipe[STAGES];
  assign b_valid = v_pipe[STAGES];

  // ---------------- step checker ----------------
  logic [WIDTH-1:0] prev_g_q;
  logic             prev_ok_q;
  logic             step_err_q;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             violation;

  assign violation = g_valid && prev_ok_q && multi_bit_step(POP_W'(g_in ^ prev_g_q));
  assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_g_q   <= '0;
      prev_ok_q  <= 1'b0;
      step_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      if (g_valid) begin
        prev_g_q  <= g_in;
        prev_ok_q <= 1'b1;
      end
      if (violation) begin
        step_err_q <= 1'b1;
        err_cnt_q  <= err_cnt_d;
      end
    end
  end

  assign step_err = step_err_q;
  assign err_cnt  = err_cnt_q;

  // ---------------- snapshot handshake ----------------
  snap_state_e      state_q, state_d;
  logic [WIDTH-1:0] snap_val_q, snap_val_d;

  always_comb begin
    state_d    = state_q;
    snap_val_d = snap_val_q;
    unique case (state_q)
      IDLE: if (snap_req) state_d = WAIT;
      // A capture wins even if the request drops in the same cycle.
      WAIT: begin
        if (b_valid) begin
          snap_val_d = b_out;
          state_d    = ACK;
        end else if (!snap_req) begin
          state_d = IDLE;
        end
      end
      ACK:  if (!snap_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      snap_val_q <= '0;
    end else begin
      state_q    <= state_d;
      snap_val_q <= snap_val_d;
    end
  end

  assign snap_ack = (state_q == ACK);
  assign snap_val = snap_val_q;

endmodule
